// File: rtl/char_terminal_ctrl.sv
// Terminal write sequencer for the character buffer: cursor tracking, CR/LF/BS/FF, scroll and clear.
// Optional CHAR_TERM_CLEAR_ON_RESET_EN: clear the whole buffer once after reset release.
module char_terminal_ctrl #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic       clk_25M,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       buf_wr_en,
    output logic [6:0] buf_wr_hchar,
    output logic [4:0] buf_wr_vchar,
    output logic [7:0] buf_wr_char,
    output logic [6:0] buf_rd_hchar,
    output logic [4:0] buf_rd_vchar,
    input  logic [7:0] buf_rd_char,
    output logic [6:0] cursor_hchar,
    output logic [4:0] cursor_vchar,
    output logic       busy
);

    localparam int unsigned CW = 7;
    localparam int unsigned RW = 5;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

`ifdef CHAR_TERM_CLEAR_ON_RESET_EN
    localparam logic INIT_CLEAR = 1'b1;
`else
    localparam logic INIT_CLEAR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, SCROLL, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          wr_en_q, wr_en_d;
    logic [CW-1:0] wr_h_q, wr_h_d;
    logic [RW-1:0] wr_v_q, wr_v_d;
    logic [7:0]    wr_c_q, wr_c_d;
    logic [CW-1:0] rd_h_q, rd_h_d;
    logic [RW-1:0] rd_v_q, rd_v_d;
    logic          rd_act_q, rd_act_d;
    logic          rd_vld_q, rd_vld_d;
    logic [CW-1:0] ptr_h_q, ptr_h_d;
    logic [RW-1:0] ptr_v_q, ptr_v_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;
    logic          init_q, init_d;

    logic xfer;
    logic start_scroll;
    logic ptr_adv;
    logic ptr_last;

    assign xfer     = in_valid & in_ready_q;
    assign ptr_last = (ptr_h_q == COL_MAX) && (ptr_v_q == ROW_MAX);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_en_d      = 1'b0;
        wr_h_d       = wr_h_q;
        wr_v_d       = wr_v_q;
        wr_c_d       = wr_c_q;
        rd_h_d       = rd_h_q;
        rd_v_d       = rd_v_q;
        rd_act_d     = rd_act_q;
        rd_vld_d     = 1'b0;
        ptr_h_d      = ptr_h_q;
        ptr_v_d      = ptr_v_q;
        init_d       = init_q;
        start_scroll = 1'b0;
        ptr_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (init_q) begin
                    init_d  = 1'b0;
                    state_d = CLEAR;
                end else if (xfer) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        wr_en_d = 1'b1;
                        wr_h_d  = col_q;
                        wr_v_d  = row_q;
                        wr_c_d  = in_char;
                        state_d = WRITE;
                    end else begin
                        case (in_char)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d = '0;
                                if (row_q < ROW_MAX) row_d = row_q + RW'(1);
                                else                 start_scroll = 1'b1;
                            end
                            8'h08: if (col_q != '0) col_d = col_q - CW'(1);
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                state_d = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (col_q < COL_MAX) begin
                    col_d = col_q + CW'(1);
                end else begin
                    col_d = '0;
                    if (row_q < ROW_MAX) row_d = row_q + RW'(1);
                    else                 start_scroll = 1'b1;
                end
            end
            SCROLL: begin
                // Read side runs one cycle ahead of the write side
                if (rd_act_q) begin
                    rd_vld_d = 1'b1;
                    if (rd_h_q == COL_MAX) begin
                        rd_h_d = '0;
                        if (rd_v_q == ROW_MAX) begin
                            rd_v_d   = '0;
                            rd_act_d = 1'b0;
                        end else begin
                            rd_v_d = rd_v_q + RW'(1);
                        end
                    end else begin
                        rd_h_d = rd_h_q + CW'(1);
                    end
                end
                if (rd_vld_q) begin
                    wr_en_d = 1'b1;
                    wr_h_d  = ptr_h_q;
                    wr_v_d  = ptr_v_q;
                    wr_c_d  = buf_rd_char;
                    ptr_adv = 1'b1;
                end else if (ptr_v_q == ROW_MAX) begin
                    wr_en_d = 1'b1;
                    wr_h_d  = ptr_h_q;
                    wr_v_d  = ptr_v_q;
                    wr_c_d  = BLANK_CHAR;
                    ptr_adv = 1'b1;
                    if (ptr_last) state_d = IDLE;
                end
            end
            CLEAR: begin
                wr_en_d = 1'b1;
                wr_h_d  = ptr_h_q;
                wr_v_d  = ptr_v_q;
                wr_c_d  = BLANK_CHAR;
                ptr_adv = 1'b1;
                if (ptr_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_scroll) begin
            state_d  = SCROLL;
            rd_h_d   = '0;
            rd_v_d   = RW'(1);
            rd_act_d = 1'b1;
        end

        // Shared row-major cell pointer for scroll writes and clear
        if (ptr_adv) begin
            if (ptr_h_q == COL_MAX) begin
                ptr_h_d = '0;
                ptr_v_d = (ptr_v_q == ROW_MAX) ? '0 : ptr_v_q + RW'(1);
            end else begin
                ptr_h_d = ptr_h_q + CW'(1);
            end
        end

        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE) && !init_d;
    end

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_h_q     <= '0;
            wr_v_q     <= '0;
            wr_c_q     <= '0;
            rd_h_q     <= '0;
            rd_v_q     <= '0;
            rd_act_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            ptr_h_q    <= '0;
            ptr_v_q    <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= !INIT_CLEAR;
            init_q     <= INIT_CLEAR;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_en_q    <= wr_en_d;
            wr_h_q     <= wr_h_d;
            wr_v_q     <= wr_v_d;
            wr_c_q     <= wr_c_d;
            rd_h_q     <= rd_h_d;
            rd_v_q     <= rd_v_d;
            rd_act_q   <= rd_act_d;
            rd_vld_q   <= rd_vld_d;
            ptr_h_q    <= ptr_h_d;
            ptr_v_q    <= ptr_v_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            init_q     <= init_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign buf_wr_en    = wr_en_q;
    assign buf_wr_hchar = wr_h_q;
    assign buf_wr_vchar = wr_v_q;
    assign buf_wr_char  = wr_c_q;
    assign buf_rd_hchar = rd_h_q;
    assign buf_rd_vchar = rd_v_q;
    assign cursor_hchar = col_q;
    assign cursor_vchar = row_q;
    assign busy         = busy_q;

endmodule
